// File: rtl/piso_serializer_8bit.sv
// Parallel-in/serial-out transmitter for the 8-bit serial bit-stream link.
// A word is accepted through a ready/load handshake and shifted out one bit
// per clock, qualified by sValid, followed by a single-cycle done pulse.
module piso_serializer_8bit #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pIn,
  input  logic             load,
  output logic             ready,
  output logic             sOut,
  output logic             sValid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] shReg;
  logic [WIDTH-1:0] shNext;
  logic [CNT_W-1:0] bitCnt;

  // Register the frame state; an asynchronous reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Shift one place toward the output end, zero-filling the vacated bit
  always_comb begin
    shNext = '0;
    if (LSB_FIRST) begin
      shNext = {1'b0, shReg[WIDTH-1:1]};
    end else begin
      shNext = {shReg[WIDTH-2:0], 1'b0};
    end
  end

  // Capture the word on acceptance, then shift and count once per bit;
  // the counter holds at the last index so it never wraps inside a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shReg  <= '0;
      bitCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shReg  <= pIn;
            bitCnt <= '0;
          end
        end
        SHIFT: begin
          shReg <= shNext;
          if (bitCnt != LAST_BIT) begin
            bitCnt <= bitCnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Advance IDLE -> SHIFT on load, SHIFT -> DONE after the last bit, DONE -> IDLE always
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load) stateNext = SHIFT;
      SHIFT:   if (bitCnt == LAST_BIT) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Decode the handshake and serial outputs from state and the shift register only
  always_comb begin
    ready  = 1'b0;
    sOut   = 1'b0;
    sValid = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        busy   = 1'b1;
        sValid = 1'b1;
        sOut   = LSB_FIRST ? shReg[0] : shReg[WIDTH-1];
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/piso_serializer_8bit.md
Name: piso_serializer_8bit

Overview:
Parallel-in/serial-out transmitter. It is the sending end of the team's 8-bit serial bit-stream link. It accepts a parallel word through a ready/load handshake and shifts it out one bit per clock, LSB first by default, qualified by a valid strobe. It ends each frame with a one-cycle done pulse. It sits between the parallel datapath and the serial-in shift-register receivers.

Parameters:
WIDTH, 8, number of bits per frame (must be >= 2)
LSB_FIRST, 1, 1 = bit 0 transmitted first (shift toward index 0); 0 = bit WIDTH-1 first

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
pIn  input  WIDTH  parallel word to transmit, sampled when load && ready
load  input  1  request to start a frame
ready  output  1  block can accept a word this cycle
sOut  output  1  serial data bit
sValid  output  1  sOut carries a frame bit this cycle
busy  output  1  frame in progress (SHIFT or DONE state)
done  output  1  one-cycle pulse after last bit of a frame

Behaviour:
- Reset (rst=0, asynchronous, takes effect without clk): state=IDLE, shift register=0, bit counter=0, ready=1, sOut=0, sValid=0, busy=0, done=0. Reset held low keeps these values.
- Reset mid-frame aborts the frame immediately. No done pulse is issued. The first frame after reset release starts cleanly.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only; none is combinational from load or pIn.
- IDLE: ready=1, busy=0, sValid=0, sOut=0. At the rising edge with load=1:
  - capture pIn into the shift register
  - clear the counter
  - go to SHIFT
  - load=0 leaves the block in IDLE.
- SHIFT: ready=0, busy=1, sValid=1.
  - sOut = shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - Each edge shifts the register one place toward the output end, fills the vacated bit with 0, and increments the counter.
  - When the counter equals WIDTH-1 at an edge, go to DONE.
- DONE: exactly one cycle. done=1, busy=1, ready=0, sValid=0, sOut=0. Next edge goes to IDLE unconditionally.
- Latency: load accepted at edge k.
  - Bit 0 of the frame is on sOut during cycle k+1, bit i during cycle k+1+i, and the last bit during cycle k+WIDTH.
  - done is high during cycle k+WIDTH+1.
  - ready is high again from cycle k+WIDTH+2.
  - Frame period with load held high: WIDTH+2 cycles.
- load while ready=0 is ignored. pIn changes during SHIFT or DONE do not affect the frame in flight.
- Counter width is clog2(WIDTH). The counter never wraps within a frame; it is cleared on acceptance.
- Exactly WIDTH sValid cycles per frame, contiguous, with no gaps.

Test Plan:
- Reset values: drive rst=0 mid-cycle with no clk edge -> ready=1, sValid=0, sOut=0, busy=0, done=0 immediately.
- LSB-first frame: pIn=8'hA5, load=1 for one cycle -> sOut during cycles k+1..k+8 = 1,0,1,0,0,1,0,1 with sValid=1, done=1 at k+9 only, ready=1 at k+10.
- Ignored load: during the 8'hA5 frame, pulse load with pIn=8'hFF at k+3 -> stream unchanged, no second frame starts.
- Back-to-back: load held high, pIn=8'h3C then 8'h81 presented at acceptance edges -> 0,0,1,1,1,1,0,0, one DONE cycle, 1,0,0,0,0,0,0,1; second frame's first bit at k+11.
- Reset mid-frame: pIn=8'hF0, assert rst=0 after the 4th bit -> outputs return to reset values at once, no done. After release, frame 8'h0F serializes as 1,1,1,1,0,0,0,0.
- MSB-first build (LSB_FIRST=0, WIDTH=8): pIn=8'hA5 -> sOut = 1,0,1,0,0,1,0,1 MSB-first order (bits 7..0). Repeat with pIn=8'h01 -> seven 0s then 1.
